// File: rtl/prbs9_ber_checker.sv
// prbs9_ber_checker: self-synchronising PRBS9 (XNOR, r[n] = r[n-9] ~^ r[n-5]) receive checker with BER counters
// Optional loss-of-lock window logic is enabled by defining PRBS9_CHK_AUTO_RESYNC_EN.
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset
//   clear      synchronous restart: counters zeroed, back to FILL, bit presented with it dropped
//   valid_in   qualifies bit_in
//   bit_in     received bit
//   locked     1 while the checker is locked
//   bit_count  valid bits checked while locked (saturating)
//   err_count  mismatches while locked (saturating)
//   err_pulse  one-cycle pulse after each mismatch counted while locked
//   lock_lost  one-cycle pulse on loss of lock (0 unless PRBS9_CHK_AUTO_RESYNC_EN)
module prbs9_ber_checker #(
    parameter int CNT_W    = 32,
    parameter int LOCK_LEN = 16,
    parameter int WIN_LEN  = 64,
    parameter int LOSS_THR = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic             valid_in,
    input  logic             bit_in,
    output logic             locked,
    output logic [CNT_W-1:0] bit_count,
    output logic [CNT_W-1:0] err_count,
    output logic             err_pulse,
    output logic             lock_lost
);
    typedef enum logic [1:0] {FILL, SEARCH, LOCKED} state_t;
    localparam int MW = $clog2(LOCK_LEN + 1);
    localparam logic [MW-1:0] MATCH_LAST = MW'(LOCK_LEN - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    state_t        state_q;
    logic [8:0]    hist_q;
    logic [3:0]    fill_q;
    logic [MW-1:0] match_q;
    logic          mism;
    // hist_q[0] is the newest bit; prediction uses the pre-shift history
    assign mism = bit_in != ~(hist_q[8] ^ hist_q[4]);
`ifdef PRBS9_CHK_AUTO_RESYNC_EN
    localparam int WW = $clog2(WIN_LEN);
    localparam int EW = $clog2(WIN_LEN + 1);
    localparam logic [WW-1:0] WIN_LAST = WW'(WIN_LEN - 1);
    logic [WW-1:0] win_q;
    logic [EW-1:0] werr_q;
    logic [EW-1:0] werr_d;
    // window error total including the bit being received now
    assign werr_d = werr_q + EW'(mism);
`else
    logic unused_cfg;
    assign unused_cfg = WIN_LEN[0] ^ LOSS_THR[0];
    assign lock_lost  = 1'b0;
`endif
    always_ff @(posedge clk or posedge reset) begin
        if (reset || clear) begin
            state_q   <= FILL;
            hist_q    <= '0;
            fill_q    <= '0;
            match_q   <= '0;
            locked    <= 1'b0;
            bit_count <= '0;
            err_count <= '0;
            err_pulse <= 1'b0;
`ifdef PRBS9_CHK_AUTO_RESYNC_EN
            lock_lost <= 1'b0;
            win_q     <= '0;
            werr_q    <= '0;
`endif
        end else begin
            err_pulse <= 1'b0;
`ifdef PRBS9_CHK_AUTO_RESYNC_EN
            lock_lost <= 1'b0;
`endif
            if (valid_in) begin
                hist_q <= {hist_q[7:0], bit_in};
                case (state_q)
                    FILL: begin
                        fill_q <= fill_q + 4'd1;
                        if (fill_q == 4'd8) state_q <= SEARCH;
                    end
                    SEARCH: begin
                        if (mism) match_q <= '0;
                        else if (match_q == MATCH_LAST) begin
                            state_q <= LOCKED;
                            locked  <= 1'b1;
                            match_q <= '0;
`ifdef PRBS9_CHK_AUTO_RESYNC_EN
                            win_q   <= '0;
                            werr_q  <= '0;
`endif
                        end else match_q <= match_q + MW'(1);
                    end
                    LOCKED: begin
                        if (bit_count != CNT_MAX) bit_count <= bit_count + CNT_W'(1);
                        if (mism) begin
                            err_pulse <= 1'b1;
                            if (err_count != CNT_MAX) err_count <= err_count + CNT_W'(1);
                        end
`ifdef PRBS9_CHK_AUTO_RESYNC_EN
                        if (win_q == WIN_LAST) begin
                            win_q  <= '0;
                            werr_q <= '0;
                            if (int'(werr_d) >= LOSS_THR) begin
                                state_q   <= SEARCH;
                                locked    <= 1'b0;
                                lock_lost <= 1'b1;
                                match_q   <= '0;
                            end
                        end else begin
                            win_q  <= win_q + WW'(1);
                            werr_q <= werr_d;
                        end
`endif
                    end
                    default: state_q <= FILL;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_prbs9_ber_checker.sv
// tb_prbs9_ber_checker: randomized and directed bench for prbs9_ber_checker against a behavioural model
module tb_prbs9_ber_checker;
    localparam int LOCK_LEN = 16;
    localparam int WIN_LEN  = 64;
    localparam int LOSS_THR = 8;
    localparam longint MAX32 = 64'hFFFF_FFFF;
    localparam longint MAX4  = 15;

    logic clk = 1'b0, reset = 1'b1, clear = 1'b0, valid_in = 1'b0, bit_in = 1'b0;
    logic locked, err_pulse, lock_lost;
    logic [31:0] bit_count, err_count;
    logic s_locked, s_err_pulse, s_lock_lost;
    logic [3:0] s_bit_count, s_err_count;

    always #5 clk = ~clk;

    prbs9_ber_checker #(.CNT_W(32), .LOCK_LEN(LOCK_LEN), .WIN_LEN(WIN_LEN), .LOSS_THR(LOSS_THR)) dut (
        .clk(clk), .reset(reset), .clear(clear), .valid_in(valid_in), .bit_in(bit_in),
        .locked(locked), .bit_count(bit_count), .err_count(err_count),
        .err_pulse(err_pulse), .lock_lost(lock_lost));

    prbs9_ber_checker #(.CNT_W(4), .LOCK_LEN(LOCK_LEN), .WIN_LEN(WIN_LEN), .LOSS_THR(LOSS_THR)) dut_s (
        .clk(clk), .reset(reset), .clear(clear), .valid_in(valid_in), .bit_in(bit_in),
        .locked(s_locked), .bit_count(s_bit_count), .err_count(s_err_count),
        .err_pulse(s_err_pulse), .lock_lost(s_lock_lost));

    int passed = 0, total = 0;

    task automatic check(input string name, input longint act, input longint exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: bits received since the last restart, lock/run bookkeeping, unbounded counts
    bit     mq[$];
    int     run, wc, we;
    bit     m_locked, m_pulse, m_lost;
    longint m_bits, m_errs;

    function automatic void model_clear();
        mq.delete();
        run = 0; wc = 0; we = 0;
        m_locked = 0; m_pulse = 0; m_lost = 0;
        m_bits = 0; m_errs = 0;
    endfunction

    function automatic void model_step(input bit v, input bit b);
        bit x9, x5, mism;
        m_pulse = 0;
        m_lost  = 0;
        if (!v) return;
        x9 = (mq.size() == 9) ? mq[0] : 1'b0;
        x5 = (mq.size() >= 5) ? mq[mq.size()-5] : 1'b0;
        mism = b != !(x9 ^ x5);
        if (!m_locked) begin
            if (mq.size() == 9) begin
                if (mism) run = 0;
                else if (++run == LOCK_LEN) begin
                    m_locked = 1; run = 0; wc = 0; we = 0;
                end
            end
        end else begin
            m_bits++;
            if (mism) begin m_errs++; m_pulse = 1; end
`ifdef PRBS9_CHK_AUTO_RESYNC_EN
            wc++;
            we += int'(mism);
            if (wc == WIN_LEN) begin
                if (we >= LOSS_THR) begin m_locked = 0; m_lost = 1; run = 0; end
                wc = 0; we = 0;
            end
`endif
        end
        mq.push_back(b);
        if (mq.size() > 9) void'(mq.pop_front());
    endfunction

    function automatic longint sat(input longint v, input longint m);
        return v > m ? m : v;
    endfunction

    initial begin
        model_clear();
        forever begin
            @(posedge clk);
            if (reset || clear) model_clear();
            else model_step(valid_in, bit_in);
            #1;
            check("locked", locked, m_locked);
            check("bit_count", bit_count, sat(m_bits, MAX32));
            check("err_count", err_count, sat(m_errs, MAX32));
            check("err_pulse", err_pulse, m_pulse);
            check("lock_lost", lock_lost, m_lost);
            check("s_locked", s_locked, m_locked);
            check("s_bit_count", s_bit_count, sat(m_bits, MAX4));
            check("s_err_count", s_err_count, sat(m_errs, MAX4));
            check("s_err_pulse", s_err_pulse, m_pulse);
        end
    end

    logic [8:0] gen;

    task automatic next_bit(output bit b);
        b = ~(gen[8] ^ gen[4]);
        gen = {gen[7:0], b};
    endtask

    task automatic send(input bit v, input bit b, input bit c);
        valid_in = v; bit_in = b; clear = c;
        @(negedge clk);
    endtask

    task automatic prbs(input int n, input bit inv);
        bit b;
        repeat (n) begin next_bit(b); send(1, b ^ inv, 0); end
    endtask

    task automatic flip();
        bit b;
        next_bit(b);
        send(1, ~b, 0);
    endtask

    task automatic restart();
        send(1, 1'($urandom), 1);
        check("restart_locked", locked, 0);
        check("restart_bits", bit_count, 0);
        check("restart_errs", err_count, 0);
    endtask

    initial begin
        bit b;
        gen = '0;
        repeat (2) @(negedge clk);
        check("reset_locked", locked, 0);
        check("reset_bits", bit_count, 0);
        check("reset_pulse", err_pulse, 0);
        reset = 1'b0;
        @(negedge clk);
        prbs(24, 0);
        check("t1_unlocked_24", locked, 0);
        prbs(1, 0);
        check("t1_locked_25", locked, 1);
        check("t1_bits_at_lock", bit_count, 0);
        prbs(975, 0);
        check("t1_bits", bit_count, 975);
        check("t1_errs", err_count, 0);
        prbs(5, 0);
        flip();
        prbs(20, 0);
        check("t2_errs", err_count, 3);
        check("t2_locked", locked, 1);
        check("t2_bits", bit_count, 1001);
        restart();
        prbs(25, 0);
        repeat (6) begin flip(); prbs(9, 0); end
        check("t6_bits", bit_count, 60);
        check("t6_errs", err_count, 18);
        check("t6_s_bits", s_bit_count, 15);
        check("t6_s_errs", s_err_count, 15);
        restart();
        prbs(500, 1);
        check("t3_locked", locked, 0);
        check("t3_bits", bit_count, 0);
        check("t3_errs", err_count, 0);
        restart();
        prbs(30, 0);
        repeat (3) begin flip(); prbs(11, 0); end
        prbs(23, 0);
`ifdef PRBS9_CHK_AUTO_RESYNC_EN
        check("t4_lost_locked", locked, 0);
        check("t4_lost_pulse", lock_lost, 1);
        check("t4_errs", err_count, 9);
        prbs(15, 0);
        check("t4_relock_15", locked, 0);
        prbs(1, 0);
        check("t4_relock_16", locked, 1);
        check("t4_kept_errs", err_count, 9);
        check("t4_kept_bits", bit_count, 64);
`else
        check("t4_locked", locked, 1);
        check("t4_errs", err_count, 9);
        check("t4_bits", bit_count, 64);
        check("t4_no_lost", lock_lost, 0);
`endif
        restart();
        for (int i = 0; i < 300; i++) begin
            next_bit(b);
            send(1, b, 0);
            send(0, 1'($urandom), 0);
        end
        check("t5_locked", locked, 1);
        check("t5_bits", bit_count, 275);
        restart();
        for (int i = 0; i < 24; i++) begin
            next_bit(b);
            send(1, b, 0);
            send(0, 1'($urandom), 0);
        end
        check("t5_relock_24", locked, 0);
        prbs(1, 0);
        check("t5_relock_25", locked, 1);
        restart();
        repeat (25) send(1, 1, 0);
        check("ones_locked", locked, 1);
        restart();
        gen = 9'($urandom);
        repeat (3000) begin
            bit v, c, f;
            v = $urandom_range(0, 9) < 7;
            c = $urandom_range(0, 999) == 0;
            f = $urandom_range(0, 99) == 0;
            if (v) next_bit(b); else b = 1'($urandom);
            send(v, b ^ f, c);
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
